// File: rtl/calc_pkg.sv
// Shared calculator-datapath constants and the multiplier state encoding.
package calc_pkg;

    localparam int unsigned MULT_W     = 16;
    localparam int unsigned PROD_W     = 32;
    localparam int unsigned MULT_ITERS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/SimpleAddFunction.sv
// 16-bit ripple-carry adder: {c_out, Q} = A + B.
module SimpleAddFunction (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        c_out,
    output logic [15:0] Q
);

    // Ripple the carry from bit 0 upward, one full adder per bit.
    always_comb begin
        logic carry;
        carry = 1'b0;
        Q     = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            Q[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        c_out = carry;
    end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier reusing one 16-bit ripple adder
// for all 16 iterations; start/busy/done handshake.
module seq_shift_add_mult
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ITER_CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   in_A,
    input  logic [WIDTH-1:0]   in_B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               ovf
);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      m_q, m_d;
    logic [2*WIDTH-1:0]    p_q, p_d;
    logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
    logic [2*WIDTH-1:0]    product_q, product_d;
    logic                  ovf_q, ovf_d;

    logic [WIDTH-1:0]      add_b;
    logic [WIDTH-1:0]      add_q;
    logic                  add_c;
    logic [2*WIDTH-1:0]    p_shift;

    // Add the multiplicand only when the current multiplier bit is set.
    assign add_b   = p_q[0] ? m_q : '0;
    // Carry enters bit 31 as the accumulator:multiplier pair shifts right.
    assign p_shift = {add_c, add_q, p_q[WIDTH-1:1]};

    SimpleAddFunction u_add (
        .A     (p_q[2*WIDTH-1:WIDTH]),
        .B     (add_b),
        .c_out (add_c),
        .Q     (add_q)
    );

    // State and datapath registers; reset clears everything, even mid-run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state and datapath update: latch in IDLE, iterate in RUN, pulse in DONE.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = in_A;
                    p_d     = {{WIDTH{1'b0}}, in_B};
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                p_d   = p_shift;
                cnt_d = cnt_q + ITER_CNT_W'(1);
                if (cnt_q == ITER_CNT_W'(MULT_ITERS - 1)) begin
                    product_d = p_shift;
                    ovf_d     = |p_shift[2*WIDTH-1:WIDTH];
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Randomised self-checking bench for seq_shift_add_mult against a plain
// arithmetic reference (a*b, high-half-nonzero flag).
module tb_seq_shift_add_mult;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] in_A;
    logic [15:0] in_B;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        ovf;

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned cyc;
    int unsigned done_cnt;
    int unsigned done_cyc[$];

    seq_shift_add_mult #(
        .WIDTH      (16),
        .ITER_CNT_W (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .in_A    (in_A),
        .in_B    (in_B),
        .busy    (busy),
        .done    (done),
        .product (product),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count done pulses and note the cycle each one appears in.
    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return p[31:0];
    endfunction

    // One full multiply; optionally pokes start during RUN to show it is ignored.
    task automatic run_mult(input logic [15:0] a, input logic [15:0] b, input bit poke);
        logic [31:0] exp_p;
        int unsigned d0;
        exp_p = ref_prod(a, b);
        @(negedge clk);
        in_A  = a;
        in_B  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        d0 = done_cnt;
        chk("busy_after_accept", 64'(busy), 64'd1);
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk);
            #1;
            in_A = 16'($urandom);
            in_B = 16'($urandom);
            if (poke) start = (i >= 3 && i <= 10);
            chk("busy_run", 64'({busy, done}), 64'b10);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("done_pulse", 64'({busy, done}), 64'b01);
        chk("product", 64'(product), 64'(exp_p));
        chk("ovf", 64'(ovf), 64'(exp_p[31:16] != 16'h0));
        @(posedge clk);
        #1;
        chk("done_drop", 64'({busy, done}), 64'b00);
        chk("product_hold", 64'(product), 64'(exp_p));
        chk("one_done", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int unsigned d0;
        n_vec    = 0;
        n_err    = 0;
        cyc      = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_A     = '0;
        in_B     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 64'({busy, done, ovf, product}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_mult(16'd3, 16'd5, 1'b0);
        run_mult(16'hFFFF, 16'hFFFF, 1'b0);
        run_mult(16'h1234, 16'h0000, 1'b0);
        run_mult(16'h0000, 16'hABCD, 1'b0);
        run_mult(16'd7, 16'd9, 1'b1);

        // Reset in the middle of a run discards it.
        @(negedge clk);
        in_A  = 16'h00FF;
        in_B  = 16'h0101;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        d0 = done_cnt;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrun_reset", 64'({busy, done, ovf, product}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
        chk("idle_after_reset", 64'({busy, product}), 64'd0);
        run_mult(16'h00FF, 16'h0101, 1'b0);

        // Back-to-back with start held high.
        @(negedge clk);
        done_cyc.delete();
        in_A  = 16'h0100;
        in_B  = 16'h0100;
        start = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("b2b_done_count", 64'(done_cyc.size()), 64'd3);
        if (done_cyc.size() >= 2)
            chk("b2b_period", 64'(done_cyc[1] - done_cyc[0]), 64'd18);
        chk("b2b_product", 64'(product), 64'(ref_prod(16'h0100, 16'h0100)));
        chk("b2b_ovf", 64'(ovf), 64'd1);

        for (int n = 0; n < 20; n++) begin
            logic [15:0] a;
            logic [15:0] b;
            a = 16'($urandom);
            b = 16'($urandom);
            if (n % 5 == 0) a = 16'($urandom_range(0, 255));
            run_mult(a, b, bit'(n % 3 == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
